if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue.sv | 57 +++++
 tb/tb_if_id_queue.sv | 116 +++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// if_id_queue: two-entry IF/ID decoupling queue with flush and HALT freeze
module if_id_queue #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] instr_in,
  input  logic [N-1:0] pc_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] instr_out,
  output logic [N-1:0] pc_out,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic         flush,
  output logic         halt_seen,
  output logic [1:0]   count
);
  localparam logic [N-1:0] NOP = N'(16'h0800);
  logic [N-1:0] r_instr [2];
  logic [N-1:0] r_pc [2];
  logic         r_wp, r_rp, r_halt;
  logic [1:0]   r_count;
  logic         w_push, w_pop, w_halt;
  assign in_ready  = !r_count[1] && !r_halt;
  assign out_valid = r_count != 2'd0;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  assign w_halt    = instr_in[N-1:N-5] == 5'b00000;
  assign instr_out = out_valid ? r_instr[r_rp] : NOP;
  assign pc_out    = out_valid ? r_pc[r_rp] : '0;
  assign halt_seen = r_halt;
  assign count     = r_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_instr <= '{default: NOP};
      r_pc    <= '{default: '0};
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_count <= 2'd0;
      r_halt  <= 1'b0;
    end else if (flush) begin
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_count <= 2'd0;
      r_halt  <= 1'b0;
    end else begin
      if (w_push) begin
        r_instr[r_wp] <= instr_in;
        r_pc[r_wp]    <= pc_in;
        r_wp          <= ~r_wp;
        if (w_halt) r_halt <= 1'b1;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed vector table plus hand-written reset sequences
module tb_if_id_queue;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, flush;
  logic [15:0] instr_in, pc_in;
  logic        in_ready, out_valid, halt_seen;
  logic [15:0] instr_out, pc_out;
  logic [1:0]  count;
  int checks = 0;
  int errors = 0;

  if_id_queue #(.N(16)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
    .in_valid(in_valid), .in_ready(in_ready), .instr_out(instr_out),
    .pc_out(pc_out), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .halt_seen(halt_seen), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] ii, pi;
    logic        ordy, fl;
    logic [1:0]  cnt;
    logic        ov, ir, h;
    logic [15:0] io, po;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [1:0] c, input logic ov, input logic ir,
                         input logic h, input logic [15:0] io, input logic [15:0] po);
    chk("count", idx, 16'(count), 16'(c));
    chk("out_valid", idx, 16'(out_valid), 16'(ov));
    chk("in_ready", idx, 16'(in_ready), 16'(ir));
    chk("halt_seen", idx, 16'(halt_seen), 16'(h));
    chk("instr_out", idx, instr_out, io);
    chk("pc_out", idx, pc_out, po);
  endtask

  task automatic drive(input logic iv, input logic [15:0] ii, input logic [15:0] pi,
                       input logic ordy, input logic fl);
    in_valid = iv; instr_in = ii; pc_in = pi; out_ready = ordy; flush = fl;
  endtask

  initial begin
    //        iv  instr     pc        ordy  fl    cnt  ov  ir  h   instr_out pc_out
    vq.push_back('{0, 16'h0000, 16'h0000, 1, 0, 2'd0, 0, 1, 0, 16'h0800, 16'h0000});
    vq.push_back('{0, 16'h0000, 16'h0000, 1, 0, 2'd0, 0, 1, 0, 16'h0800, 16'h0000});
    vq.push_back('{0, 16'h0000, 16'h0000, 1, 0, 2'd0, 0, 1, 0, 16'h0800, 16'h0000});
    vq.push_back('{1, 16'h4001, 16'h0002, 0, 0, 2'd1, 1, 1, 0, 16'h4001, 16'h0002});
    vq.push_back('{1, 16'h4002, 16'h0004, 0, 0, 2'd2, 1, 0, 0, 16'h4001, 16'h0002});
    vq.push_back('{1, 16'h4003, 16'h0006, 0, 0, 2'd2, 1, 0, 0, 16'h4001, 16'h0002});
    vq.push_back('{0, 16'h0000, 16'h0000, 1, 0, 2'd1, 1, 1, 0, 16'h4002, 16'h0004});
    vq.push_back('{0, 16'h0000, 16'h0000, 1, 0, 2'd0, 0, 1, 0, 16'h0800, 16'h0000});
    vq.push_back('{1, 16'h5001, 16'h0010, 1, 0, 2'd1, 1, 1, 0, 16'h5001, 16'h0010});
    vq.push_back('{1, 16'h5002, 16'h0012, 1, 0, 2'd1, 1, 1, 0, 16'h5002, 16'h0012});
    vq.push_back('{1, 16'h5003, 16'h0014, 1, 0, 2'd1, 1, 1, 0, 16'h5003, 16'h0014});
    vq.push_back('{0, 16'h0000, 16'h0000, 1, 0, 2'd0, 0, 1, 0, 16'h0800, 16'h0000});
    vq.push_back('{1, 16'h6001, 16'h0020, 0, 0, 2'd1, 1, 1, 0, 16'h6001, 16'h0020});
    vq.push_back('{1, 16'h6002, 16'h0022, 0, 0, 2'd2, 1, 0, 0, 16'h6001, 16'h0020});
    vq.push_back('{1, 16'h6003, 16'h0024, 1, 1, 2'd0, 0, 1, 0, 16'h0800, 16'h0000});
    vq.push_back('{1, 16'h7001, 16'h0030, 0, 0, 2'd1, 1, 1, 0, 16'h7001, 16'h0030});
    vq.push_back('{0, 16'h0000, 16'h0000, 1, 0, 2'd0, 0, 1, 0, 16'h0800, 16'h0000});
    vq.push_back('{1, 16'h0000, 16'h0040, 0, 0, 2'd1, 1, 0, 1, 16'h0000, 16'h0040});
    vq.push_back('{1, 16'h4444, 16'h0042, 0, 0, 2'd1, 1, 0, 1, 16'h0000, 16'h0040});
    vq.push_back('{1, 16'h4444, 16'h0042, 1, 0, 2'd0, 0, 0, 1, 16'h0800, 16'h0000});
    vq.push_back('{1, 16'h4445, 16'h0044, 0, 0, 2'd0, 0, 0, 1, 16'h0800, 16'h0000});
    vq.push_back('{1, 16'h4446, 16'h0046, 0, 1, 2'd0, 0, 1, 0, 16'h0800, 16'h0000});
    vq.push_back('{1, 16'h4555, 16'h0050, 0, 0, 2'd1, 1, 1, 0, 16'h4555, 16'h0050});
    vq.push_back('{1, 16'h4556, 16'h0052, 1, 0, 2'd1, 1, 1, 0, 16'h4556, 16'h0052});
    vq.push_back('{1, 16'h07ff, 16'h0054, 1, 0, 2'd1, 1, 0, 1, 16'h07ff, 16'h0054});

    rst = 1'b1;
    drive(0, 16'h0, 16'h0, 0, 0);
    #1 chk_all(-1, 2'd0, 0, 1, 0, 16'h0800, 16'h0000);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].iv, vq[i].ii, vq[i].pi, vq[i].ordy, vq[i].fl);
      @(posedge clk);
      #1 chk_all(i, vq[i].cnt, vq[i].ov, vq[i].ir, vq[i].h, vq[i].io, vq[i].po);
    end

    // clear halt, fill to two, then assert reset between edges
    drive(0, 16'h0, 16'h0, 0, 1);
    @(posedge clk);
    #1 drive(1, 16'h4101, 16'h0060, 0, 0);
    @(posedge clk);
    #1 drive(1, 16'h4102, 16'h0062, 0, 0);
    @(posedge clk);
    #1 chk_all(100, 2'd2, 1, 0, 0, 16'h4101, 16'h0060);
    drive(0, 16'h0, 16'h0, 1, 0);
    #2 rst = 1'b1;
    #1 chk_all(101, 2'd0, 0, 1, 0, 16'h0800, 16'h0000);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 chk_all(102, 2'd0, 0, 1, 0, 16'h0800, 16'h0000);
    drive(1, 16'h4201, 16'h0070, 0, 0);
    @(posedge clk);
    #1 chk_all(103, 2'd1, 1, 1, 0, 16'h4201, 16'h0070);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
